// File: rtl/srrc_rx_flt_ctrl.sv
// ----------------------------------------------------------------------------
// srrc_rx_flt_ctrl
//   Timing and sequencing controller for the RX SRRC matched filter. Divides
//   the system clock into sample and symbol strobes, tracks filter fill so
//   downstream slicers can ignore start-up and flush transients, and applies
//   one-sample symbol-phase advance/retard requests from timing recovery.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-low reset
//   run            1 = strobes free-run, 0 = counters hold and strobes are 0
//   flush_req      1-clk pulse, restart fill tracking
//   phase_adv_req  level, shorten the next symbol by one sample
//   phase_ret_req  level, lengthen the next symbol by one sample
//   phase_ack      1-clk pulse, request completed
//   sam_clk_en     1-clk sample strobe
//   sym_clk_en     1-clk symbol strobe, always coincident with sam_clk_en
//   flt_valid      filter output is fully primed
//   sym_phase      accumulated phase offset, two's-complement wrap
//
// All outputs come straight from registers. A strobe is visible in the cycle
// after the clock edge at which the internal tick fired.
// ----------------------------------------------------------------------------
module srrc_rx_flt_ctrl #(
    parameter int unsigned SAM_DIV = 4,
    parameter int unsigned SPS     = 4,
    parameter int unsigned NTAPS   = 199,
    parameter int unsigned LAT_SAM = 2,
    parameter int unsigned CNT_W   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       flush_req,
    input  logic       phase_adv_req,
    input  logic       phase_ret_req,
    output logic       phase_ack,
    output logic       sam_clk_en,
    output logic       sym_clk_en,
    output logic       flt_valid,
    output logic [1:0] sym_phase
);

    localparam int unsigned ClkW      = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1;
    // sym_cnt must reach SPS while a retard is being applied
    localparam int unsigned SymW      = $clog2(SPS + 1);
    localparam int unsigned FillEnd   = NTAPS + LAT_SAM;
    localparam int unsigned TermAdv   = (SPS >= 2) ? SPS - 2 : 0;
    localparam bit          NoShorten = (SPS < 2);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ClkW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [SymW-1:0]  sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             pend_q, pend_d;
    logic             pend_adv_q, pend_adv_d;
    logic [1:0]       phase_q, phase_d;
    logic             sam_en_q, sym_en_q, valid_q, ack_q;

    logic            sam_tick, sym_tick;
    logic [SymW-1:0] adj_term, term;
    logic            adj_now, adj_done;
    logic            accept, noop, latch;

    always_comb begin
        sam_tick = run && (clk_cnt_q == ClkW'(SAM_DIV - 1));

        clk_cnt_d = clk_cnt_q;
        if (run) begin
            clk_cnt_d = sam_tick ? '0 : clk_cnt_q + 1'b1;
        end

        // A pending adjust takes effect on the current symbol only if the
        // count has not already passed the adjusted terminal value.
        adj_term = pend_adv_q ? SymW'(TermAdv) : SymW'(SPS);
        adj_now  = pend_q && (sym_cnt_q <= adj_term);
        term     = adj_now ? adj_term : SymW'(SPS - 1);
        sym_tick = sam_tick && (sym_cnt_q == term);
        adj_done = sym_tick && adj_now;

        sym_cnt_d = sym_cnt_q;
        if (sam_tick) begin
            sym_cnt_d = sym_tick ? '0 : sym_cnt_q + 1'b1;
        end

        // Conflicting requests, or an advance that cannot shorten a
        // one-sample symbol, complete at once without touching timing.
        accept = run && !pend_q && (phase_adv_req || phase_ret_req);
        noop   = accept && ((phase_adv_req && phase_ret_req) ||
                            (phase_adv_req && NoShorten));
        latch  = accept && !noop;

        pend_d     = pend_q;
        pend_adv_d = pend_adv_q;
        if (adj_done) begin
            pend_d = 1'b0;
        end else if (latch) begin
            pend_d     = 1'b1;
            pend_adv_d = phase_adv_req;
        end

        phase_d = phase_q;
        if (adj_done) begin
            phase_d = pend_adv_q ? phase_q + 2'd1 : phase_q - 2'd1;
        end

        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d    = StFill;
                    fill_cnt_d = '0;
                end
            end
            StFill: begin
                if (flush_req) begin
                    fill_cnt_d = '0;
                end else if (sam_tick) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == CNT_W'(FillEnd - 1)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (flush_req) begin
                    state_d    = StFill;
                    fill_cnt_d = '0;
                end
            end
            default: begin
                state_d    = StIdle;
                fill_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            clk_cnt_q  <= '0;
            sym_cnt_q  <= '0;
            fill_cnt_q <= '0;
            pend_q     <= 1'b0;
            pend_adv_q <= 1'b0;
            phase_q    <= 2'd0;
            sam_en_q   <= 1'b0;
            sym_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            pend_q     <= pend_d;
            pend_adv_q <= pend_adv_d;
            phase_q    <= phase_d;
            sam_en_q   <= sam_tick;
            sym_en_q   <= sym_tick;
            // One clk behind the state so valid rises after the final fill strobe
            valid_q    <= (state_q == StRun);
            ack_q      <= adj_done || noop;
        end
    end

    assign sam_clk_en = sam_en_q;
    assign sym_clk_en = sym_en_q;
    assign flt_valid  = valid_q;
    assign phase_ack  = ack_q;
    assign sym_phase  = phase_q;

endmodule

// File: tb/tb_srrc_rx_flt_ctrl.sv
module tb_srrc_rx_flt_ctrl;

    localparam int SAM_DIV = 4;
    localparam int SPS     = 4;
    localparam int NTAPS   = 199;
    localparam int LAT_SAM = 2;

    logic       clk = 1'b0;
    logic       reset, run, flush_req, phase_adv_req, phase_ret_req;
    logic       phase_ack, sam_clk_en, sym_clk_en, flt_valid;
    logic [1:0] sym_phase;

    int checks = 0;
    int fails  = 0;
    int cyc    = -1;
    int last_sym = -1000;
    int sym_gap  = 0;

    // Reference model: counts of run clocks, samples and strobes.
    int         m_runclk, m_sis, m_stage, m_fill, m_pend, m_phase;
    logic       e_sam, e_sym, e_valid, e_ack;
    logic [1:0] e_phase;

    srrc_rx_flt_ctrl #(
        .SAM_DIV(SAM_DIV), .SPS(SPS), .NTAPS(NTAPS), .LAT_SAM(LAT_SAM), .CNT_W(9)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .flush_req    (flush_req),
        .phase_adv_req(phase_adv_req),
        .phase_ret_req(phase_ret_req),
        .phase_ack    (phase_ack),
        .sam_clk_en   (sam_clk_en),
        .sym_clk_en   (sym_clk_en),
        .flt_valid    (flt_valid),
        .sym_phase    (sym_phase)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit sam;
        int len;
        int pend_before;
        if (!reset) begin
            m_runclk = 0; m_sis = 0; m_stage = 0; m_fill = 0; m_pend = 0; m_phase = 0;
            e_sam = 0; e_sym = 0; e_valid = 0; e_ack = 0; e_phase = 2'd0;
            return;
        end
        e_valid = (m_stage == 2);
        sam = run && ((m_runclk % SAM_DIV) == SAM_DIV - 1);
        if (run) m_runclk++;
        e_sam = sam; e_sym = 0; e_ack = 0;
        pend_before = m_pend;
        if (sam) begin
            len = SPS;
            if (m_pend == 1 && m_sis <= SPS - 2) len = SPS - 1;
            else if (m_pend == 2) len = SPS + 1;
            if (m_sis + 1 == len) begin
                e_sym = 1;
                m_sis = 0;
                if (len != SPS) begin
                    e_ack = 1;
                    m_phase = (m_phase + ((m_pend == 1) ? 1 : SPS - 1)) % SPS;
                    m_pend = 0;
                end
            end else begin
                m_sis++;
            end
        end
        if (pend_before == 0 && run && (phase_adv_req || phase_ret_req)) begin
            if (phase_adv_req && phase_ret_req) e_ack = 1;
            else m_pend = phase_adv_req ? 1 : 2;
        end
        if (flush_req && m_stage != 0) begin
            m_stage = 1; m_fill = 0;
        end else if (m_stage == 0) begin
            if (run) begin m_stage = 1; m_fill = 0; end
        end else if (m_stage == 1 && sam) begin
            m_fill++;
            if (m_fill == NTAPS + LAT_SAM) m_stage = 2;
        end
        e_phase = 2'(m_phase);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (sym_clk_en) begin
            sym_gap  = cyc - last_sym;
            last_sym = cyc;
        end
    endtask

    task automatic test_reset();
        reset = 0; run = 0; flush_req = 0; phase_adv_req = 0; phase_ret_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase} !== 6'b0) begin
                fails++;
                $display("FAIL reset_outputs got=%b required=000000",
                         {sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase});
            end
        end
    endtask

    task automatic test_startup();
        reset = 1; run = 1; cyc = -1;
        for (int i = 0; i < 48; i++) begin
            tick();
            checks++;
            if (sam_clk_en !== ((cyc % 4) == 3) || sym_clk_en !== ((cyc % 16) == 15) ||
                flt_valid !== 1'b0) begin
                fails++;
                $display("FAIL startup_strobes cyc=%0d got sam=%b sym=%b vld=%b", cyc,
                         sam_clk_en, sym_clk_en, flt_valid);
            end
        end
    endtask

    task automatic test_fill();
        while (cyc < 820) begin
            tick();
            checks++;
            if ({sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase} !==
                {e_sam, e_sym, e_valid, e_ack, e_phase}) begin
                fails++;
                $display("FAIL fill_model cyc=%0d got=%b required=%b", cyc,
                         {sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase},
                         {e_sam, e_sym, e_valid, e_ack, e_phase});
            end
            if (cyc == 803 || cyc == 804 || cyc == 820) begin
                checks++;
                if (flt_valid !== (cyc >= 804)) begin
                    fails++;
                    $display("FAIL fill_valid_edge cyc=%0d got=%b required=%b", cyc,
                             flt_valid, (cyc >= 804));
                end
            end
        end
    endtask

    // Holds one request until the model predicts its ack, then checks the
    // completing symbol's period and the new phase.
    task automatic do_adjust(input bit adv, input int gap_req, input logic [1:0] ph_req);
        bit done = 0;
        phase_adv_req = adv; phase_ret_req = !adv;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (e_ack) begin
                done = 1;
                checks++;
                if (phase_ack !== 1'b1 || sym_clk_en !== 1'b1 || sym_gap != gap_req ||
                    sym_phase !== ph_req) begin
                    fails++;
                    $display("FAIL adjust_%s cyc=%0d got ack=%b sym=%b gap=%0d ph=%0d required 1 1 %0d %0d",
                             adv ? "adv" : "ret", cyc, phase_ack, sym_clk_en, sym_gap,
                             sym_phase, gap_req, ph_req);
                end
            end
        end
        if (!done) begin
            fails++; checks++;
            $display("FAIL adjust_timeout got no ack required ack within 100 clks");
        end
        phase_adv_req = 0; phase_ret_req = 0;
    endtask

    task automatic test_phase();
        int seen;
        while (cyc < 899) tick();
        do_adjust(1'b1, 12, 2'd1);
        do_adjust(1'b0, 20, 2'd0);
        phase_adv_req = 1; phase_ret_req = 1;
        tick();
        checks++;
        if (phase_ack !== 1'b1 || sym_phase !== 2'd0) begin
            fails++;
            $display("FAIL both_req_ack got ack=%b ph=%0d required ack=1 ph=0",
                     phase_ack, sym_phase);
        end
        phase_adv_req = 0; phase_ret_req = 0;
        seen = 0;
        for (int i = 0; i < 80 && seen < 3; i++) begin
            tick();
            if (sym_clk_en) begin
                seen++;
                if (seen > 1) begin
                    checks++;
                    if (sym_gap != 16 || phase_ack !== 1'b0) begin
                        fails++;
                        $display("FAIL both_req_period got gap=%0d ack=%b required 16 0",
                                 sym_gap, phase_ack);
                    end
                end
            end
        end
    endtask

    task automatic test_flush();
        int strobes = 0;
        bit up = 0;
        flush_req = 1;
        tick();
        flush_req = 0;
        tick();
        checks++;
        if (flt_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop got=%b required=0", flt_valid);
        end
        if (sam_clk_en) strobes++;
        for (int i = 0; i < 1000 && !up; i++) begin
            tick();
            if (flt_valid) up = 1;
            else if (sam_clk_en) strobes++;
            if (sym_clk_en) begin
                checks++;
                if (sym_gap != 16) begin
                    fails++;
                    $display("FAIL flush_sym_period got=%0d required=16", sym_gap);
                end
            end
        end
        checks++;
        if (!up || strobes != 201) begin
            fails++;
            $display("FAIL flush_refill got strobes=%0d rose=%0d required 201 1", strobes, up);
        end
    endtask

    task automatic test_run_pause();
        run = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (sam_clk_en !== 1'b0 || sym_clk_en !== 1'b0 || flt_valid !== e_valid) begin
                fails++;
                $display("FAIL pause_hold cyc=%0d got sam=%b sym=%b vld=%b", cyc,
                         sam_clk_en, sym_clk_en, flt_valid);
            end
        end
        run = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ({sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase} !==
                {e_sam, e_sym, e_valid, e_ack, e_phase}) begin
                fails++;
                $display("FAIL pause_resume cyc=%0d got=%b required=%b", cyc,
                         {sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase},
                         {e_sam, e_sym, e_valid, e_ack, e_phase});
            end
        end
    endtask

    task automatic test_random();
        bit req_on = 0;
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom % 30) != 0;
            flush_req = ($urandom % 500) == 0;
            if (!req_on && ($urandom % 40) == 0) begin
                req_on = 1;
                case ($urandom % 3)
                    0: begin phase_adv_req = 1; phase_ret_req = 0; end
                    1: begin phase_adv_req = 0; phase_ret_req = 1; end
                    default: begin phase_adv_req = 1; phase_ret_req = 1; end
                endcase
            end
            tick();
            checks++;
            if ({sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase} !==
                {e_sam, e_sym, e_valid, e_ack, e_phase}) begin
                fails++;
                $display("FAIL random_model cyc=%0d got=%b required=%b", cyc,
                         {sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase},
                         {e_sam, e_sym, e_valid, e_ack, e_phase});
            end
            if (e_ack) begin
                req_on = 0; phase_adv_req = 0; phase_ret_req = 0;
            end
        end
        run = 1; flush_req = 0; phase_adv_req = 0; phase_ret_req = 0;
    endtask

    task automatic test_reset_mid();
        flush_req = 1;
        tick();
        flush_req = 0;
        phase_adv_req = 1;
        tick();
        phase_adv_req = 0;
        reset = 0;
        tick();
        checks++;
        if ({sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase} !== 6'b0) begin
            fails++;
            $display("FAIL reset_mid_outputs got=%b required=000000",
                     {sam_clk_en, sym_clk_en, flt_valid, phase_ack, sym_phase});
        end
        reset = 1; cyc = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if (phase_ack !== 1'b0 || flt_valid !== 1'b0 || sam_clk_en !== ((cyc % 4) == 3) ||
                {sym_clk_en, sym_phase} !== {e_sym, e_phase}) begin
                fails++;
                $display("FAIL reset_mid_restart cyc=%0d got ack=%b vld=%b sam=%b sym=%b ph=%0d",
                         cyc, phase_ack, flt_valid, sam_clk_en, sym_clk_en, sym_phase);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_fill();
        test_phase();
        test_flush();
        test_run_pause();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
